// File: rtl/byte_unstriping.sv
// Two-lane receive merge: each lane feeds a small circular FIFO, and the
// FIFOs are drained in strict lane 1, lane 0 alternation into one stream.
module byte_unstriping #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clock1,
  input  logic                          reset_L,
  input  logic [DATA_WIDTH-1:0]         lane_0,
  input  logic [DATA_WIDTH-1:0]         lane_1,
  input  logic                          valid0,
  input  logic                          valid1,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          valid_out,
  output logic [$clog2(FIFO_DEPTH):0]   fill0,
  output logic [$clog2(FIFO_DEPTH):0]   fill1,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [2][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] din [2];
  logic [AW-1:0]         wptr [2];
  logic [AW-1:0]         rptr [2];
  logic [CW-1:0]         cnt [2];
  logic [1:0]            vin;
  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0]            drop;
  logic                  next_lane;

  assign din[0] = lane_0;
  assign din[1] = lane_1;
  assign vin    = {valid1, valid0};
  assign fill0  = cnt[0];
  assign fill1  = cnt[1];

  // Only the lane whose turn it is may pop; a full lane still accepts a push when it pops.
  always_comb begin
    pop  = '0;
    push = '0;
    drop = '0;
    for (int l = 0; l < 2; l++) begin
      pop[l]  = (next_lane == 1'(l)) && (cnt[l] != '0);
      push[l] = vin[l] && ((cnt[l] != CW'(FIFO_DEPTH)) || pop[l]);
      drop[l] = vin[l] && (cnt[l] == CW'(FIFO_DEPTH)) && !pop[l];
    end
  end

  // Storage array is not reset; pointers and counts define valid contents.
  always_ff @(posedge clock1) begin
    for (int l = 0; l < 2; l++) begin
      if (push[l]) mem[l][wptr[l]] <= din[l];
    end
  end

  always_ff @(posedge clock1 or negedge reset_L) begin
    if (!reset_L) begin
      for (int l = 0; l < 2; l++) begin
        wptr[l] <= '0;
        rptr[l] <= '0;
        cnt[l]  <= '0;
      end
      next_lane <= 1'b1;
      data_out  <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (push[l]) wptr[l] <= wptr[l] + AW'(1);
        if (pop[l])  rptr[l] <= rptr[l] + AW'(1);
        if (push[l] && !pop[l])      cnt[l] <= cnt[l] + CW'(1);
        else if (!push[l] && pop[l]) cnt[l] <= cnt[l] - CW'(1);
      end
      if (|pop) begin
        data_out  <= mem[next_lane][rptr[next_lane]];
        valid_out <= 1'b1;
        next_lane <= ~next_lane;
      end else begin
        valid_out <= 1'b0;
      end
      if (|drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping: expected merge order is queued at
// stimulus time and a forked monitor checks every valid output word.
module tb_byte_unstriping;

  localparam int unsigned DW = 32;

  logic          clock1 = 1'b0;
  logic          reset_L = 1'b0;
  logic [DW-1:0] lane_0 = '0;
  logic [DW-1:0] lane_1 = '0;
  logic          valid0 = 1'b0;
  logic          valid1 = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [2:0]    fill0;
  logic [2:0]    fill1;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q [$];

  byte_unstriping #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clock1(clock1), .reset_L(reset_L),
    .lane_0(lane_0), .lane_1(lane_1),
    .valid0(valid0), .valid1(valid1),
    .data_out(data_out), .valid_out(valid_out),
    .fill0(fill0), .fill1(fill1), .overflow(overflow)
  );

  always #5 clock1 = ~clock1;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Present one beat to the next rising edge, then drop the valids.
  task automatic beat(input logic v0, input logic [DW-1:0] d0,
                      input logic v1, input logic [DW-1:0] d1);
    lane_0 = d0; valid0 = v0;
    lane_1 = d1; valid1 = v1;
    @(posedge clock1);
    #1;
    valid0 = 1'b0;
    valid1 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clock1);
        if (reset_L && valid_out) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", longint'(data_out), 64'hFFFF_FFFF_FFFF);
          end else begin
            check("stream_word", longint'(data_out), longint'(exp_q.pop_front()));
          end
        end
      end
    join_none

    // Reset state
    #2;
    check("rst_data_out", data_out, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_fill0", fill0, 0);
    check("rst_fill1", fill1, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clock1);
    reset_L = 1'b1;

    // Aligned stream
    exp_q.push_back(32'hA1A1_0001); exp_q.push_back(32'hA0A0_0000);
    exp_q.push_back(32'hB1B1_0001); exp_q.push_back(32'hB0B0_0000);
    beat(1'b1, 32'hA0A0_0000, 1'b1, 32'hA1A1_0001);
    @(negedge clock1);
    check("aligned_fill0", fill0, 1);
    check("aligned_fill1", fill1, 1);
    idle(1);
    beat(1'b1, 32'hB0B0_0000, 1'b1, 32'hB1B1_0001);
    idle(5);

    // Skew: lane 0 three cycles ahead of lane 1
    exp_q.push_back(32'hC1C1_0001); exp_q.push_back(32'hC0C0_0000);
    exp_q.push_back(32'hD1D1_0001); exp_q.push_back(32'hD0D0_0000);
    beat(1'b1, 32'hC0C0_0000, 1'b0, '0);
    beat(1'b1, 32'hD0D0_0000, 1'b0, '0);
    @(negedge clock1);
    check("skew_fill0_peak", fill0, 2);
    check("skew_hold_valid", valid_out, 0);
    idle(1);
    beat(1'b0, '0, 1'b1, 32'hC1C1_0001);
    @(negedge clock1);
    check("skew_wait_valid", valid_out, 0);
    check("skew_fill0_held", fill0, 2);
    beat(1'b0, '0, 1'b1, 32'hD1D1_0001);
    idle(6);

    // Invalid word ignored
    beat(1'b0, 32'hDEAD_BEEF, 1'b0, '0);
    @(negedge clock1);
    check("invalid_fill0", fill0, 0);
    idle(3);

    // Lane 1 full while its turn comes up: push accepted alongside the pop
    exp_q.push_back(32'h0000_0A01); exp_q.push_back(32'h0000_0B00);
    exp_q.push_back(32'h0000_0101); exp_q.push_back(32'h0000_0C00);
    exp_q.push_back(32'h0000_0201); exp_q.push_back(32'h0000_0D00);
    exp_q.push_back(32'h0000_0301); exp_q.push_back(32'h0000_0E00);
    exp_q.push_back(32'h0000_0401); exp_q.push_back(32'h0000_0F00);
    exp_q.push_back(32'h0000_0501);
    beat(1'b0, '0, 1'b1, 32'h0000_0A01);
    for (int i = 1; i <= 4; i++) beat(1'b0, '0, 1'b1, DW'(i * 256 + 1));
    @(negedge clock1);
    check("full1_fill1", fill1, 4);
    beat(1'b1, 32'h0000_0B00, 1'b0, '0);
    idle(1);
    beat(1'b0, '0, 1'b1, 32'h0000_0501);
    @(negedge clock1);
    check("full_pop_fill1", fill1, 4);
    check("full_pop_no_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) beat(1'b1, DW'(32'h0C00 + i * 256), 1'b0, '0);
    idle(12);

    // Realign so lane 1 is next, then overflow lane 0
    exp_q.push_back(32'h0000_1100);
    beat(1'b1, 32'h0000_1100, 1'b0, '0);
    idle(3);
    for (int i = 0; i < 4; i++) beat(1'b1, DW'(32'hE000 + i), 1'b0, '0);
    @(negedge clock1);
    check("ovf_fill0_full", fill0, 4);
    check("ovf_not_yet", overflow, 0);
    beat(1'b1, 32'h0000_E004, 1'b0, '0);
    @(negedge clock1);
    check("ovf_fill0_after_drop", fill0, 4);
    check("ovf_set", overflow, 1);
    idle(3);
    check("ovf_sticky", overflow, 1);

    // Drain two words, then reset mid-stream while valid_out is high
    exp_q.push_back(32'h0000_F001); exp_q.push_back(32'h0000_E000);
    beat(1'b0, '0, 1'b1, 32'h0000_F001);
    idle(2);
    #6;
    reset_L = 1'b0;
    #1;
    check("midrst_data_out", data_out, 0);
    check("midrst_valid_out", valid_out, 0);
    check("midrst_fill0", fill0, 0);
    check("midrst_fill1", fill1, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_queue_drained", exp_q.size(), 0);
    @(posedge clock1);
    @(negedge clock1);
    reset_L = 1'b1;

    // After reset lane 1 is read first even if lane 0 arrives earlier
    exp_q.push_back(32'h5151_0001); exp_q.push_back(32'h5050_0000);
    beat(1'b1, 32'h5050_0000, 1'b0, '0);
    @(negedge clock1);
    check("postrst_wait_lane1", valid_out, 0);
    beat(1'b0, '0, 1'b1, 32'h5151_0001);
    idle(5);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_fill0", fill0, 0);
    check("final_fill1", fill1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/byte_unstriping.md
# byte_unstriping

Lane-merge stage on the receive side of the two-lane link. It accepts 32-bit words on lane 0 and lane 1, each with its own valid, and buffers each lane in a small FIFO to absorb lane-to-lane skew. It re-interleaves the words into a single stream in the strict order lane 1, lane 0, lane 1, … and so rebuilds the word sequence that the byte-striping stage split across the lanes. The block runs entirely on one clock, whose rate must support the combined rate of both lanes.

## Interface
- DATA_WIDTH, 32, word width of each lane and of the merged output.
- FIFO_DEPTH, 4, entries per lane FIFO; must be a power of 2 and at least 2.
- clock1  in  1  sole clock; all state updates on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- lane_0  in  DATA_WIDTH  lane 0 word.
- lane_1  in  DATA_WIDTH  lane 1 word.
- valid0  in  1  lane_0 holds a word to be captured this cycle.
- valid1  in  1  lane_1 holds a word to be captured this cycle.
- data_out  out  DATA_WIDTH  merged word, registered.
- valid_out  out  1  data_out holds a new word this cycle, registered.
- fill0  out  $clog2(FIFO_DEPTH)+1  lane 0 FIFO occupancy.
- fill1  out  $clog2(FIFO_DEPTH)+1  lane 1 FIFO occupancy.
- overflow  out  1  sticky flag: a valid word was dropped on either lane.

## Operation
- Each lane FIFO is circular, with read and write pointers that wrap modulo FIFO_DEPTH and an occupancy counter that runs from 0 to FIFO_DEPTH.
- Write on lane N: when validN=1, the word is captured, unless the FIFO is full and no pop of that lane occurs in the same cycle. Words with validN=0 are ignored, whatever their data value.
- Dropped write: when validN=1, fillN=FIFO_DEPTH and no pop of lane N occurs, the word is discarded, the pointers are left unchanged and overflow is set to 1. overflow stays at 1 until reset.
- Merge selector next_lane is 1 bit, reset to 1, so lane 1 is read first.
- Each cycle, if FIFO[next_lane] is non-empty:
  - pop its head into data_out;
  - set valid_out=1;
  - toggle next_lane.
- If FIFO[next_lane] is empty:
  - set valid_out=0;
  - data_out holds its previous value;
  - next_lane is unchanged. The other lane is never read out of turn, even if it holds data.
- Simultaneous push and pop on one lane in the same cycle: the occupancy count is unchanged and both pointers advance. This applies when the lane is full: the push is accepted.
- A push into an empty FIFO cannot be popped in the same cycle; there is no fall-through.
- Reset is asynchronous and may be asserted mid-operation. It clears both FIFOs (pointers and counts to 0), sets next_lane=1 and forces every output to its reset value. The storage array contents need not be cleared.

## Timing
- Reset values:
  - data_out=0, valid_out=0;
  - fill0=0, fill1=0;
  - overflow=0.
- Latency: a word captured at rising edge k appears at the earliest on data_out with valid_out=1 after edge k+1.
- fill0 and fill1 reflect the registered state after each edge: a push increments, a pop decrements, and a simultaneous push and pop leaves the count unchanged.
- overflow rises at the same edge that discards the word.
- Throughput: at most one output word per cycle. Sustained input on both lanes every cycle exceeds this, so upstream must keep the average combined input rate at or below one word per clock.

## Test plan
- Reset behaviour:
  - stimulus: assert reset_L=0 mid-stream;
  - required: all outputs go to 0 immediately, without waiting for a clock edge;
  - required after release: the first popped word comes from lane 1.
- Aligned stream:
  - stimulus: push lane_1=A1 and lane_0=A0 in the same cycle, then B1/B0 two cycles later;
  - required: data_out sequence A1, A0, B1, B0, with valid_out=1 on each of those four cycles.
- Skew:
  - stimulus: lane 0 words C0 and D0 arrive 3 cycles before lane 1 words C1 and D1;
  - required: no output until C1 is captured; then data_out = C1, C0, D1, D0, and fill0 peaks at 2.
- Overflow:
  - stimulus: push 5 words on lane 0 with FIFO_DEPTH=4 and lane 1 idle;
  - required: fill0=4, the 5th word is dropped, overflow=1, and overflow stays at 1 until reset.
- Full with simultaneous pop:
  - stimulus: lane 1 full, next_lane=1, valid1=1;
  - required: the new word is accepted and fill1 stays at 4.
- Invalid ignored:
  - stimulus: lane_0=0xDEADBEEF with valid0=0;
  - required: fill0 is unchanged and the value never appears on data_out.
